scan_chain_reader: RTL and testbench

Readback engine for chains of static D flip-flops, such as configuration or scan chains. On a start pulse it drives the chain's shift enable and samples the chain tail bit each cycle. It packs the sampled bits LSB-first into WORD_W-bit words and hands them out over a valid/ready interface, stalling the chain while the consumer back-pressures. It sits at the far end of the chain, opposite the flip-flops' D inputs.

---
 rtl/scan_chain_reader_pkg.sv | 29 ++
 rtl/scan_chain_reader_packer.sv | 47 ++++
 rtl/scan_chain_reader.sv | 101 ++++++++++
 tb/tb_scan_chain_reader.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_chain_reader_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// scan_chain_reader_pkg : FSM encoding and sizing helpers for the chain reader
// Rev 1.0
// ---------------------------------------------------------------------------
package scan_chain_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SHIFT   = 2'd1,
    ST_PRESENT = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int WORDS_OF(input int len, input int w);
    return (len + w - 1) / w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/scan_chain_reader_packer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// scan_word_packer : LSB-first serial-to-parallel word assembler
// Rev 1.0
// ---------------------------------------------------------------------------
module scan_word_packer
  import scan_chain_reader_pkg::*;
#(
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load_bit,
  input  logic              i_clear,
  input  logic              i_bit_in,
  output logic [WORD_W-1:0] o_word,
  output logic              o_full
);

  localparam int IDX_W = clog2(WORD_W + 1);
  localparam logic [IDX_W-1:0] c_IDX_TOP  = IDX_W'(WORD_W);
  localparam logic [IDX_W-1:0] c_IDX_LAST = IDX_W'(WORD_W - 1);

  logic [WORD_W-1:0] r_pack;
  logic [IDX_W-1:0]  r_bit_idx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pack    <= '0;
      r_bit_idx <= '0;
    end else if (i_clear) begin
      r_pack    <= '0;
      r_bit_idx <= '0;
    end else if (i_load_bit && (r_bit_idx != c_IDX_TOP)) begin
      for (int i = 0; i < WORD_W; i++) begin
        if (r_bit_idx == IDX_W'(i)) r_pack[i] <= i_bit_in;
      end
      r_bit_idx <= r_bit_idx + 1'b1;
    end
  end

  assign o_word = r_pack;
  // Flags the load that completes the word, so the FSM can leave SHIFT on that same edge
  assign o_full = (r_bit_idx == c_IDX_LAST);

endmodule
`default_nettype wire

// File: rtl/scan_chain_reader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// scan_chain_reader : shifts a flip-flop chain out and delivers it as words
// Rev 1.0
// ---------------------------------------------------------------------------
module scan_chain_reader
  import scan_chain_reader_pkg::*;
#(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              sc_en,
  input  logic              sc_tail,
  output logic [WORD_W-1:0] word_data,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              word_last
);

  localparam int CNT_W     = clog2(CHAIN_LEN + 1);
  localparam int NUM_WORDS = WORDS_OF(CHAIN_LEN, WORD_W);
  localparam int WC_W      = clog2(NUM_WORDS + 1);
  localparam logic [CNT_W-1:0] c_LEN     = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] c_LEN_M1  = CNT_W'(CHAIN_LEN - 1);
  localparam logic [WC_W-1:0]  c_WC_LAST = WC_W'(NUM_WORDS - 1);
  localparam logic [WC_W-1:0]  c_WC_TOP  = WC_W'(NUM_WORDS);

  state_t            r_state;
  logic [CNT_W-1:0]  r_shift_cnt;
  logic [WC_W-1:0]   r_word_cnt;

  logic              w_shift;
  logic              w_present;
  logic              w_last;
  logic              w_hs;
  logic              w_pk_clear;
  logic              w_pk_full;
  logic [WORD_W-1:0] w_pk_word;

  assign w_shift    = (r_state == ST_SHIFT);
  assign w_present  = (r_state == ST_PRESENT);
  assign w_last     = (r_shift_cnt == c_LEN) && (r_word_cnt == c_WC_LAST);
  assign w_hs       = w_present && word_ready;
  assign w_pk_clear = ((r_state == ST_IDLE) && start) || (w_hs && !w_last);

  scan_word_packer #(
    .WORD_W (WORD_W)
  ) u_packer (
    .clk        (clk),
    .reset      (reset),
    .i_load_bit (w_shift),
    .i_clear    (w_pk_clear),
    .i_bit_in   (sc_tail),
    .o_word     (w_pk_word),
    .o_full     (w_pk_full)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_shift_cnt <= '0;
      r_word_cnt  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state     <= ST_SHIFT;
            r_shift_cnt <= '0;
            r_word_cnt  <= '0;
          end
        end
        ST_SHIFT: begin
          if (r_shift_cnt != c_LEN) r_shift_cnt <= r_shift_cnt + 1'b1;
          if (w_pk_full || (r_shift_cnt == c_LEN_M1)) r_state <= ST_PRESENT;
        end
        ST_PRESENT: begin
          if (word_ready) begin
            if (r_word_cnt != c_WC_TOP) r_word_cnt <= r_word_cnt + 1'b1;
            r_state <= w_last ? ST_DONE : ST_SHIFT;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy       = (r_state != ST_IDLE);
  assign done       = (r_state == ST_DONE);
  assign sc_en      = w_shift;
  assign word_valid = w_present;
  assign word_data  = w_present ? w_pk_word : '0;
  assign word_last  = w_present && w_last;

endmodule
`default_nettype wire

// File: tb/tb_scan_chain_reader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_scan_chain_reader : directed bench, three readers (16/8, 20/8, 3/8)
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_scan_chain_reader;
  import scan_chain_reader_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] start = '0, busy, done, sc_en, sc_tail, valid, last;
  logic [2:0] ready = 3'b111;
  logic [7:0] data [3];

  logic [2:0]  load_req = '0;
  logic [31:0] load_val [3];
  logic [31:0] chain [3];
  logic [2:0]  clr = '0;

  logic [7:0] mw [3][4];
  logic       ml [3][4];
  int men [3], mnw [3], mdc [3], mdcyc [3], mcyc [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  scan_chain_reader #(.CHAIN_LEN(16), .WORD_W(8)) u_d0 (
    .clk(clk), .reset(rst_n), .start(start[0]), .busy(busy[0]), .done(done[0]),
    .sc_en(sc_en[0]), .sc_tail(sc_tail[0]), .word_data(data[0]), .word_valid(valid[0]),
    .word_ready(ready[0]), .word_last(last[0]));
  scan_chain_reader #(.CHAIN_LEN(20), .WORD_W(8)) u_d1 (
    .clk(clk), .reset(rst_n), .start(start[1]), .busy(busy[1]), .done(done[1]),
    .sc_en(sc_en[1]), .sc_tail(sc_tail[1]), .word_data(data[1]), .word_valid(valid[1]),
    .word_ready(ready[1]), .word_last(last[1]));
  scan_chain_reader #(.CHAIN_LEN(3), .WORD_W(8)) u_d2 (
    .clk(clk), .reset(rst_n), .start(start[2]), .busy(busy[2]), .done(done[2]),
    .sc_en(sc_en[2]), .sc_tail(sc_tail[2]), .word_data(data[2]), .word_valid(valid[2]),
    .word_ready(ready[2]), .word_last(last[2]));

  // Chain model: tail is bit 0, zeros enter at the head
  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (load_req[d])   chain[d] <= load_val[d];
      else if (sc_en[d]) chain[d] <= chain[d] >> 1;
    end
  end
  assign sc_tail = {chain[2][0], chain[1][0], chain[0][0]};

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (clr[d]) begin
        mcyc[d] <= 0; men[d] <= 0; mnw[d] <= 0; mdc[d] <= 0; mdcyc[d] <= 0;
      end else begin
        mcyc[d] <= mcyc[d] + 1;
        if (sc_en[d]) men[d] <= men[d] + 1;
        if (valid[d] && ready[d] && mnw[d] < 4) begin
          mw[d][mnw[d]] <= data[d];
          ml[d][mnw[d]] <= last[d];
          mnw[d]        <= mnw[d] + 1;
        end
        if (done[d]) begin
          mdc[d]   <= mdc[d] + 1;
          mdcyc[d] <= mcyc[d] + 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_chain(input int d, input logic [31:0] v);
    load_req[d] = 1'b1;
    load_val[d] = v;
    tick();
    load_req[d] = 1'b0;
  endtask

  task automatic begin_rd(input int d);
    start[d] = 1'b1;
    clr[d]   = 1'b1;
    tick();
    start[d] = 1'b0;
    clr[d]   = 1'b0;
  endtask

  task automatic wait_idle(input int d, input int budget);
    int n = 0;
    while (busy[d] && n < budget) begin
      tick();
      n++;
    end
    n_checks++;
    if (busy[d] !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_idle dut%0d: busy=%b after %0d cycles, required 0", d, busy[d], budget);
    end
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if ({busy, done, sc_en, valid, last} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b required 0", {busy, done, sc_en, valid, last});
    end
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if (data[d] !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_data dut%0d: got %h required 00", d, data[d]);
      end
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    load_chain(0, 32'hA55A);
    begin_rd(0);
    repeat (18) tick();
    n_checks++;
    if ({done[0], busy[0]} !== 2'b11) begin
      n_fail++;
      $display("FAIL basic_done_c19: done,busy=%b required 11", {done[0], busy[0]});
    end
    tick();
    n_checks++;
    if ({done[0], busy[0]} !== 2'b00) begin
      n_fail++;
      $display("FAIL basic_idle_c20: done,busy=%b required 00", {done[0], busy[0]});
    end
    n_checks++;
    if (mnw[0] !== 2 || mw[0][0] !== 8'h5A || mw[0][1] !== 8'hA5) begin
      n_fail++;
      $display("FAIL basic_words: n=%0d w0=%h w1=%h required 2 5a a5", mnw[0], mw[0][0], mw[0][1]);
    end
    n_checks++;
    if (ml[0][0] !== 1'b0 || ml[0][1] !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_last: got %b%b required 01", ml[0][0], ml[0][1]);
    end
    n_checks++;
    if (men[0] !== 16 || mdc[0] !== 1 || mdcyc[0] !== 19) begin
      n_fail++;
      $display("FAIL basic_timing: sc_en=%0d dones=%0d done_cyc=%0d required 16 1 19",
               men[0], mdc[0], mdcyc[0]);
    end
  endtask

  task automatic test_padding();
    load_chain(1, 32'h000F_1234);
    begin_rd(1);
    wait_idle(1, 40);
    n_checks++;
    if (mnw[1] !== 3 || mw[1][0] !== 8'h34 || mw[1][1] !== 8'h12 || mw[1][2] !== 8'h0F) begin
      n_fail++;
      $display("FAIL pad_words: n=%0d %h %h %h required 3 34 12 0f",
               mnw[1], mw[1][0], mw[1][1], mw[1][2]);
    end
    n_checks++;
    if ({ml[1][0], ml[1][1], ml[1][2]} !== 3'b001) begin
      n_fail++;
      $display("FAIL pad_last: got %b%b%b required 001", ml[1][0], ml[1][1], ml[1][2]);
    end
    n_checks++;
    if (men[1] !== 20 || mdc[1] !== 1) begin
      n_fail++;
      $display("FAIL pad_counts: sc_en=%0d dones=%0d required 20 1", men[1], mdc[1]);
    end
  endtask

  task automatic test_backpressure();
    load_chain(0, 32'hA55A);
    ready[0] = 1'b0;
    begin_rd(0);
    repeat (8) tick();
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({valid[0], sc_en[0], last[0]} !== 3'b100 || data[0] !== 8'h5A) begin
        n_fail++;
        $display("FAIL stall_%0d: valid,sc_en,last=%b data=%h required 100 5a",
                 i, {valid[0], sc_en[0], last[0]}, data[0]);
      end
      tick();
    end
    ready[0] = 1'b1;
    wait_idle(0, 40);
    n_checks++;
    if (mnw[0] !== 2 || mw[0][0] !== 8'h5A || mw[0][1] !== 8'hA5 || ml[0][1] !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_words: n=%0d %h %h last=%b required 2 5a a5 1",
               mnw[0], mw[0][0], mw[0][1], ml[0][1]);
    end
    n_checks++;
    if (men[0] !== 16 || mdc[0] !== 1 || mdcyc[0] !== 24) begin
      n_fail++;
      $display("FAIL stall_timing: sc_en=%0d dones=%0d done_cyc=%0d required 16 1 24",
               men[0], mdc[0], mdcyc[0]);
    end
  endtask

  task automatic test_back_to_back_start();
    int n = 0;
    load_chain(0, 32'hC3E1);
    begin_rd(0);
    repeat (3) tick();
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    while (!done[0] && n < 40) begin
      tick();
      n++;
    end
    n_checks++;
    if (done[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL ign_done_seen: done=%b required 1", done[0]);
    end
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    n_checks++;
    if ({busy[0], done[0]} !== 2'b00) begin
      n_fail++;
      $display("FAIL ign_busy_fall: busy,done=%b required 00", {busy[0], done[0]});
    end
    repeat (4) tick();
    n_checks++;
    if (busy[0] !== 1'b0 || mdc[0] !== 1 || men[0] !== 16) begin
      n_fail++;
      $display("FAIL ign_single: busy=%b dones=%0d sc_en=%0d required 0 1 16",
               busy[0], mdc[0], men[0]);
    end
    n_checks++;
    if (mnw[0] !== 2 || mw[0][0] !== 8'hE1 || mw[0][1] !== 8'hC3) begin
      n_fail++;
      $display("FAIL ign_words: n=%0d %h %h required 2 e1 c3", mnw[0], mw[0][0], mw[0][1]);
    end
  endtask

  task automatic test_abort();
    load_chain(0, 32'hA55A);
    begin_rd(0);
    repeat (12) tick();
    n_checks++;
    if (sc_en[0] !== 1'b1 || men[0] !== 11) begin
      n_fail++;
      $display("FAIL abort_pre: sc_en=%b shifted=%0d required 1 11", sc_en[0], men[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy[0], done[0], sc_en[0], valid[0], last[0]} !== 5'd0 || data[0] !== 8'h00) begin
      n_fail++;
      $display("FAIL abort_async: ctrl=%b data=%h required 00000 00",
               {busy[0], done[0], sc_en[0], valid[0], last[0]}, data[0]);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (mdc[0] !== 0 || busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_no_done: dones=%0d busy=%b required 0 0", mdc[0], busy[0]);
    end
    begin_rd(0);
    wait_idle(0, 40);
    n_checks++;
    if (mnw[0] !== 2 || mw[0][0] !== 8'h14 || mw[0][1] !== 8'h00 || mdc[0] !== 1 || men[0] !== 16) begin
      n_fail++;
      $display("FAIL abort_resume: n=%0d %h %h dones=%0d sc_en=%0d required 2 14 00 1 16",
               mnw[0], mw[0][0], mw[0][1], mdc[0], men[0]);
    end
  endtask

  task automatic test_short_chain();
    load_chain(2, 32'h5);
    begin_rd(2);
    wait_idle(2, 20);
    n_checks++;
    if (mnw[2] !== WORDS_OF(3, 8) || mw[2][0] !== 8'h05 || ml[2][0] !== 1'b1) begin
      n_fail++;
      $display("FAIL short_word: n=%0d %h last=%b required 1 05 1", mnw[2], mw[2][0], ml[2][0]);
    end
    n_checks++;
    if (men[2] !== 3 || mdc[2] !== 1 || mdcyc[2] !== 5) begin
      n_fail++;
      $display("FAIL short_timing: sc_en=%0d dones=%0d done_cyc=%0d required 3 1 5",
               men[2], mdc[2], mdcyc[2]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_padding();
    test_backpressure();
    test_back_to_back_start();
    test_abort();
    test_short_chain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
